// File: rtl/adder_result_checker.sv
// Response checker for a WIDTH-bit adder: compares each applied {a,b,cin} against the
// DUT's {cout,sum}, counts vectors/mismatches, captures the first failure, reports pass.
module adder_result_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 512,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t state;

  // Full-width reference sum; the carry-out is the extra top bit.
  function automatic logic [WIDTH:0] expected_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH:0] exp_p0;
  logic [WIDTH:0] got_p0;
  logic           mismatch_p0;
  logic           vld_p0;
  logic           last_p0;

  assign exp_p0      = expected_sum(in_a, in_b, in_cin);
  assign got_p0      = {dut_cout, dut_sum};
  assign mismatch_p0 = (got_p0 != exp_p0);
  assign vld_p0      = in_valid && (state == RUN);
  assign last_p0     = (vec_count == LAST_IDX);

  // p0 -> registered results: everything updates on the edge that samples the vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else if (start && (state != RUN)) begin
      // Entering RUN drops any vector presented on the same edge.
      state      <= RUN;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else if (vld_p0) begin
      vec_count <= vec_count + CNT_W'(1);
      if (mismatch_p0) begin
        err_count <= sat_inc(err_count);
      end
      if (mismatch_p0 && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= in_a;
        fail_b     <= in_b;
        fail_cin   <= in_cin;
        fail_exp   <= exp_p0;
        fail_got   <= got_p0;
      end
      if (last_p0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_count == '0) && !mismatch_p0;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: full runs, first-failure capture, gapped valids,
// mid-run reset and restart from DONE.
module tb_adder_result_checker;

  localparam int WIDTH = 4;
  localparam int NV    = 512;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_cin, dut_cout;
  logic [WIDTH-1:0] in_a, in_b, dut_sum;
  logic             busy, done, pass, fail_valid, fail_cin;
  logic [CNT_W-1:0] vec_count, err_count;
  logic [WIDTH-1:0] fail_a, fail_b;
  logic [WIDTH:0]   fail_exp, fail_got;

  int n_assert = 0;
  int n_fail   = 0;

  adder_result_checker #(.WIDTH(WIDTH), .NUM_VECTORS(NV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    r = 5'(a) + 5'(b) + 5'(c);
    return r;
  endfunction

  // Present one vector with the given DUT response for one cycle.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] got);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    {dut_cout, dut_sum} = got;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive_good(input int k);
    logic [8:0] v;
    v = 9'(k);
    drive(v[3:0], v[7:4], v[8], ref_sum(v[3:0], v[7:4], v[8]));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_vec", 32'(vec_count), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_fvalid", 32'(fail_valid), 0);
    chk("rst_fgot", 32'(fail_got), 0);

    // Valids while IDLE are ignored.
    drive_good(5);
    drive(4'h3, 4'h3, 1'b0, 5'h1F);
    chk("idle_vec", 32'(vec_count), 0);
    chk("idle_err", 32'(err_count), 0);
    chk("idle_busy", 32'(busy), 0);

    // Run 1: start with a simultaneous valid (dropped), then exhaustive good vectors.
    start = 1'b1; in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; in_cin = 1'b0;
    {dut_cout, dut_sum} = 5'h00;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("r1_start_busy", 32'(busy), 1);
    chk("r1_start_vec", 32'(vec_count), 0);
    chk("r1_start_err", 32'(err_count), 0);
    for (int k = 0; k < NV; k++) begin
      drive_good(k);
      if (k == NV - 2) begin
        chk("r1_pre_last_vec", 32'(vec_count), 511);
        chk("r1_pre_last_busy", 32'(busy), 1);
        chk("r1_pre_last_done", 32'(done), 0);
      end
    end
    chk("r1_done", 32'(done), 1);
    chk("r1_busy", 32'(busy), 0);
    chk("r1_vec", 32'(vec_count), 512);
    chk("r1_err", 32'(err_count), 0);
    chk("r1_pass", 32'(pass), 1);
    chk("r1_fvalid", 32'(fail_valid), 0);

    // Valids in DONE are ignored; results hold.
    drive(4'h2, 4'h2, 1'b0, 5'h00);
    chk("done_hold_vec", 32'(vec_count), 512);
    chk("done_hold_err", 32'(err_count), 0);
    chk("done_hold_done", 32'(done), 1);

    // Run 2: start together with in_valid in DONE restarts and drops that vector.
    start = 1'b1; in_valid = 1'b1; in_a = 4'h7; in_b = 4'h7; in_cin = 1'b1;
    {dut_cout, dut_sum} = 5'h00;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("r2_restart_busy", 32'(busy), 1);
    chk("r2_restart_done", 32'(done), 0);
    chk("r2_restart_vec", 32'(vec_count), 0);
    chk("r2_restart_err", 32'(err_count), 0);
    chk("r2_restart_pass", 32'(pass), 0);

    // Gapped valids; mismatches at vectors 3 and 7.
    for (int k = 0; k < NV; k++) begin
      if (k == 3) begin
        drive(4'hF, 4'h1, 1'b1, 5'h01);
        chk("v3_err", 32'(err_count), 1);
        chk("v3_fvalid", 32'(fail_valid), 1);
        chk("v3_fa", 32'(fail_a), 32'hF);
        chk("v3_fb", 32'(fail_b), 32'h1);
        chk("v3_fcin", 32'(fail_cin), 1);
        chk("v3_fexp", 32'(fail_exp), 32'h11);
        chk("v3_fgot", 32'(fail_got), 32'h01);
      end else if (k == 7) begin
        drive(4'h7, 4'h0, 1'b0, 5'h17);
        chk("v7_err", 32'(err_count), 2);
        chk("v7_fa_hold", 32'(fail_a), 32'hF);
        chk("v7_fgot_hold", 32'(fail_got), 32'h01);
      end else begin
        drive_good(k);
      end
      tick();
      if (k == 10) chk("gap_vec", 32'(vec_count), 11);
      if (k == NV - 2) chk("r2_pre_last_done", 32'(done), 0);
    end
    chk("r2_done", 32'(done), 1);
    chk("r2_busy", 32'(busy), 0);
    chk("r2_vec", 32'(vec_count), 512);
    chk("r2_err", 32'(err_count), 2);
    chk("r2_pass", 32'(pass), 0);
    chk("r2_fexp", 32'(fail_exp), 32'h11);

    // Run 3: reset at vector 100 overrides start and in_valid.
    do_start();
    for (int k = 0; k < 100; k++) drive_good(k);
    chk("r3_vec100", 32'(vec_count), 100);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_a = 4'h1; in_b = 4'h2; in_cin = 1'b0;
    {dut_cout, dut_sum} = 5'h1F;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("r3_rst_busy", 32'(busy), 0);
    chk("r3_rst_done", 32'(done), 0);
    chk("r3_rst_vec", 32'(vec_count), 0);
    chk("r3_rst_err", 32'(err_count), 0);
    chk("r3_rst_fvalid", 32'(fail_valid), 0);

    // Run 4: clean rerun after reset.
    do_start();
    chk("r4_busy", 32'(busy), 1);
    for (int k = 0; k < NV; k++) drive_good(NV - 1 - k);
    chk("r4_done", 32'(done), 1);
    chk("r4_vec", 32'(vec_count), 512);
    chk("r4_err", 32'(err_count), 0);
    chk("r4_pass", 32'(pass), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
